// File: rtl/cdb_writeback_rf_if.sv
// Signal bundle between the CDB, the operand collector, the scoreboard and the
// writeback register file.
interface cdb_writeback_rf_if #(
    parameter int WARP_W = 3,
    parameter int REG_W  = 3,
    parameter int LANES  = 8,
    parameter int DATA_W = 256
);
    logic              RegWrite_CDB_RAU;
    logic [WARP_W-1:0] HWWarp_CDB_RAU;
    logic [REG_W-1:0]  WriteAddr_CDB_RAU;
    logic [DATA_W-1:0] Data_CDB_RAU;
    logic [LANES-1:0]  ActiveMask_CDB_RAU;

    logic              RdEn_A_OC_RAU;
    logic [WARP_W-1:0] RdWarp_A_OC_RAU;
    logic [REG_W-1:0]  RdAddr_A_OC_RAU;
    logic              RdEn_B_OC_RAU;
    logic [WARP_W-1:0] RdWarp_B_OC_RAU;
    logic [REG_W-1:0]  RdAddr_B_OC_RAU;

    logic [DATA_W-1:0] RdData_A_RAU_OC;
    logic              RdValid_A_RAU_OC;
    logic [DATA_W-1:0] RdData_B_RAU_OC;
    logic              RdValid_B_RAU_OC;

    logic              Release_RAU_SB;
    logic [WARP_W-1:0] ReleaseWarp_RAU_SB;
    logic [REG_W-1:0]  ReleaseReg_RAU_SB;
    logic [15:0]       WbCount_RAU;

    modport master (
        output RegWrite_CDB_RAU, HWWarp_CDB_RAU, WriteAddr_CDB_RAU, Data_CDB_RAU,
               ActiveMask_CDB_RAU,
        output RdEn_A_OC_RAU, RdWarp_A_OC_RAU, RdAddr_A_OC_RAU,
        output RdEn_B_OC_RAU, RdWarp_B_OC_RAU, RdAddr_B_OC_RAU,
        input  RdData_A_RAU_OC, RdValid_A_RAU_OC, RdData_B_RAU_OC, RdValid_B_RAU_OC,
        input  Release_RAU_SB, ReleaseWarp_RAU_SB, ReleaseReg_RAU_SB, WbCount_RAU
    );

    modport slave (
        input  RegWrite_CDB_RAU, HWWarp_CDB_RAU, WriteAddr_CDB_RAU, Data_CDB_RAU,
               ActiveMask_CDB_RAU,
        input  RdEn_A_OC_RAU, RdWarp_A_OC_RAU, RdAddr_A_OC_RAU,
        input  RdEn_B_OC_RAU, RdWarp_B_OC_RAU, RdAddr_B_OC_RAU,
        output RdData_A_RAU_OC, RdValid_A_RAU_OC, RdData_B_RAU_OC, RdValid_B_RAU_OC,
        output Release_RAU_SB, ReleaseWarp_RAU_SB, ReleaseReg_RAU_SB, WbCount_RAU
    );
endinterface

// File: rtl/cdb_writeback_rf.sv
// CDB writeback into the per-warp register file: capture, masked commit,
// scoreboard release and two write-first synchronous read ports.
module cdb_writeback_rf #(
    parameter int NUM_WARPS = 8,
    parameter int NUM_REGS  = 8,
    parameter int LANES     = 8,
    parameter int LANE_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    cdb_writeback_rf_if.slave   bus
);
    localparam int DATA_W = LANES * LANE_W;
    localparam int WARP_W = $clog2(NUM_WARPS);
    localparam int REG_W  = $clog2(NUM_REGS);
    localparam int DEPTH  = NUM_WARPS * NUM_REGS;
    localparam int IDX_W  = WARP_W + REG_W;

    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [LANES-1:0]  mask
    );
        lane_merge = old_v;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) lane_merge[i*LANE_W +: LANE_W] = new_v[i*LANE_W +: LANE_W];
        end
    endfunction

    logic [DATA_W-1:0] r_rf [DEPTH];

    logic              r_vld_p0;
    logic [WARP_W-1:0] r_warp_p0;
    logic [REG_W-1:0]  r_reg_p0;
    logic [DATA_W-1:0] r_data_p0;
    logic [LANES-1:0]  r_mask_p0;

    logic              r_vld_p1;
    logic [WARP_W-1:0] r_warp_p1;
    logic [REG_W-1:0]  r_reg_p1;
    logic [15:0]       r_wb_cnt;

    logic              r_rd_vld_a, r_rd_vld_b;
    logic [DATA_W-1:0] r_rd_data_a, r_rd_data_b;

    logic [IDX_W-1:0]  w_wr_idx, w_rd_idx_a, w_rd_idx_b;
    logic [DATA_W-1:0] w_merged, w_rd_a, w_rd_b;

    assign w_wr_idx   = {r_warp_p0, r_reg_p0};
    assign w_rd_idx_a = {bus.RdWarp_A_OC_RAU, bus.RdAddr_A_OC_RAU};
    assign w_rd_idx_b = {bus.RdWarp_B_OC_RAU, bus.RdAddr_B_OC_RAU};
    assign w_merged   = lane_merge(r_rf[w_wr_idx], r_data_p0, r_mask_p0);

    // Write-first: a read hitting the entry being committed sees the merged value
    assign w_rd_a = (r_vld_p0 && (w_rd_idx_a == w_wr_idx)) ? w_merged : r_rf[w_rd_idx_a];
    assign w_rd_b = (r_vld_p0 && (w_rd_idx_b == w_wr_idx)) ? w_merged : r_rf[w_rd_idx_b];

    // Stage C: capture payload; only its valid bit needs reset
    always_ff @(posedge clk) begin
        if (bus.RegWrite_CDB_RAU) begin
            r_warp_p0 <= bus.HWWarp_CDB_RAU;
            r_reg_p0  <= bus.WriteAddr_CDB_RAU;
            r_data_p0 <= bus.Data_CDB_RAU;
            r_mask_p0 <= bus.ActiveMask_CDB_RAU;
        end
    end

    // Stage W: commit, release, counter and read ports
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_warp_p1   <= '0;
            r_reg_p1    <= '0;
            r_wb_cnt    <= '0;
            r_rd_vld_a  <= 1'b0;
            r_rd_vld_b  <= 1'b0;
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
        end else begin
            r_vld_p0 <= bus.RegWrite_CDB_RAU;
            if (r_vld_p0) begin
                r_rf[w_wr_idx] <= w_merged;
                r_wb_cnt       <= r_wb_cnt + 16'd1;
            end
            r_vld_p1   <= r_vld_p0;
            r_warp_p1  <= r_vld_p0 ? r_warp_p0 : '0;
            r_reg_p1   <= r_vld_p0 ? r_reg_p0  : '0;
            r_rd_vld_a <= bus.RdEn_A_OC_RAU;
            r_rd_vld_b <= bus.RdEn_B_OC_RAU;
            if (bus.RdEn_A_OC_RAU) r_rd_data_a <= w_rd_a;
            if (bus.RdEn_B_OC_RAU) r_rd_data_b <= w_rd_b;
        end
    end

    assign bus.RdData_A_RAU_OC    = r_rd_data_a;
    assign bus.RdValid_A_RAU_OC   = r_rd_vld_a;
    assign bus.RdData_B_RAU_OC    = r_rd_data_b;
    assign bus.RdValid_B_RAU_OC   = r_rd_vld_b;
    assign bus.Release_RAU_SB     = r_vld_p1;
    assign bus.ReleaseWarp_RAU_SB = r_warp_p1;
    assign bus.ReleaseReg_RAU_SB  = r_reg_p1;
    assign bus.WbCount_RAU        = r_wb_cnt;
endmodule

// File: tb/tb_cdb_writeback_rf.sv
// Directed bench for cdb_writeback_rf: inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_cdb_writeback_rf;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    cdb_writeback_rf_if bus ();

    cdb_writeback_rf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cdb(input logic en, input logic [2:0] w, input logic [2:0] r,
                       input logic [255:0] d, input logic [7:0] m);
        bus.RegWrite_CDB_RAU   = en;
        bus.HWWarp_CDB_RAU     = w;
        bus.WriteAddr_CDB_RAU  = r;
        bus.Data_CDB_RAU       = d;
        bus.ActiveMask_CDB_RAU = m;
    endtask

    task automatic rd_a(input logic en, input logic [2:0] w, input logic [2:0] r);
        bus.RdEn_A_OC_RAU   = en;
        bus.RdWarp_A_OC_RAU = w;
        bus.RdAddr_A_OC_RAU = r;
    endtask

    task automatic rd_b(input logic en, input logic [2:0] w, input logic [2:0] r);
        bus.RdEn_B_OC_RAU   = en;
        bus.RdWarp_B_OC_RAU = w;
        bus.RdAddr_B_OC_RAU = r;
    endtask

    task automatic check_rel(input string tag, input logic v, input logic [2:0] w,
                             input logic [2:0] r);
        check({tag, "_rel"},  256'(bus.Release_RAU_SB), 256'(v));
        check({tag, "_warp"}, 256'(bus.ReleaseWarp_RAU_SB), 256'(w));
        check({tag, "_reg"},  256'(bus.ReleaseReg_RAU_SB), 256'(r));
    endtask

    logic [255:0] pat, all_a, all_5, merged, old_v, new_v, d7;

    initial begin
        for (int i = 0; i < 8; i++) pat[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        all_a  = {8{32'hAAAA_AAAA}};
        all_5  = {8{32'h5555_5555}};
        merged = {{4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}};
        old_v  = {8{32'h1111_1111}};
        new_v  = {8{32'h2222_2222}};

        rst_n = 1'b0;
        cdb(1'b0, 3'd0, 3'd0, '0, 8'h00);
        rd_a(1'b0, 3'd0, 3'd0);
        rd_b(1'b0, 3'd0, 3'd0);
        tick();
        tick();
        check_rel("reset", 1'b0, 3'd0, 3'd0);
        check("reset_cnt", 256'(bus.WbCount_RAU), 256'd0);
        check("reset_vld_a", 256'(bus.RdValid_A_RAU_OC), 256'd0);
        rst_n = 1'b1;

        // read of a reset entry
        rd_a(1'b1, 3'd3, 3'd5);
        tick();
        check("rst_rd_vld", 256'(bus.RdValid_A_RAU_OC), 256'd1);
        check("rst_rd_data", bus.RdData_A_RAU_OC, 256'd0);
        rd_a(1'b0, 3'd0, 3'd0);
        tick();
        check("rd_vld_drop", 256'(bus.RdValid_A_RAU_OC), 256'd0);
        check("rd_data_hold", bus.RdData_A_RAU_OC, 256'd0);

        // full-mask write, release exactly two edges later
        cdb(1'b1, 3'd2, 3'd4, pat, 8'hFF);
        tick();
        cdb(1'b0, 3'd0, 3'd0, '0, 8'h00);
        check_rel("w1_t1", 1'b0, 3'd0, 3'd0);
        tick();
        check_rel("w1_t2", 1'b1, 3'd2, 3'd4);
        check("w1_cnt", 256'(bus.WbCount_RAU), 256'd1);
        rd_a(1'b1, 3'd2, 3'd4);
        tick();
        rd_a(1'b0, 3'd0, 3'd0);
        check_rel("w1_t3", 1'b0, 3'd0, 3'd0);
        check("w1_data", bus.RdData_A_RAU_OC, pat);

        // partial mask merges over previous contents
        cdb(1'b1, 3'd0, 3'd0, all_a, 8'hFF);
        tick();
        cdb(1'b1, 3'd0, 3'd0, all_5, 8'h0F);
        tick();
        cdb(1'b0, 3'd0, 3'd0, '0, 8'h00);
        tick();
        rd_a(1'b1, 3'd0, 3'd0);
        tick();
        rd_a(1'b0, 3'd0, 3'd0);
        check("mask_merge", bus.RdData_A_RAU_OC, merged);
        check("mask_cnt", 256'(bus.WbCount_RAU), 256'd3);

        // write-first on commit edge, old data while still in capture
        cdb(1'b1, 3'd1, 3'd1, old_v, 8'hFF);
        tick();
        cdb(1'b0, 3'd0, 3'd0, '0, 8'h00);
        tick();
        cdb(1'b1, 3'd1, 3'd1, new_v, 8'hFF);
        rd_b(1'b1, 3'd1, 3'd1);
        tick();
        cdb(1'b0, 3'd0, 3'd0, '0, 8'h00);
        rd_b(1'b0, 3'd0, 3'd0);
        rd_a(1'b1, 3'd1, 3'd1);
        check("collide_b_old", bus.RdData_B_RAU_OC, old_v);
        tick();
        rd_a(1'b0, 3'd0, 3'd0);
        check("collide_a_new", bus.RdData_A_RAU_OC, new_v);
        check("collide_cnt", 256'(bus.WbCount_RAU), 256'd5);

        // eight back-to-back writes to warp 7
        for (int r = 0; r < 10; r++) begin
            if (r < 8) begin
                for (int i = 0; i < 8; i++) d7[i*32 +: 32] = 32'h7000_0000 | (r << 8) | i;
                cdb(1'b1, 3'd7, 3'(r), d7, 8'hFF);
            end else begin
                cdb(1'b0, 3'd0, 3'd0, '0, 8'h00);
            end
            tick();
            if (r >= 1 && r <= 8) check_rel($sformatf("b2b%0d", r - 1), 1'b1, 3'd7, 3'(r - 1));
        end
        check_rel("b2b_end", 1'b0, 3'd0, 3'd0);
        check("b2b_cnt", 256'(bus.WbCount_RAU), 256'd13);
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) d7[i*32 +: 32] = 32'h7000_0000 | (r << 8) | i;
            rd_a(1'b1, 3'd7, 3'(r));
            rd_b(1'b1, 3'd7, 3'(r));
            tick();
            check($sformatf("b2b_rd_a%0d", r), bus.RdData_A_RAU_OC, d7);
            check($sformatf("b2b_rd_b%0d", r), bus.RdData_B_RAU_OC, d7);
        end
        rd_a(1'b0, 3'd0, 3'd0);
        rd_b(1'b0, 3'd0, 3'd0);

        // reset between capture and commit drops the write
        cdb(1'b1, 3'd4, 3'd6, pat, 8'hFF);
        tick();
        cdb(1'b0, 3'd0, 3'd0, '0, 8'h00);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_rel("rstmid_t2", 1'b0, 3'd0, 3'd0);
        check("rstmid_cnt", 256'(bus.WbCount_RAU), 256'd0);
        rd_a(1'b1, 3'd4, 3'd6);
        rd_b(1'b1, 3'd2, 3'd4);
        tick();
        rd_a(1'b0, 3'd0, 3'd0);
        rd_b(1'b0, 3'd0, 3'd0);
        check_rel("rstmid_t3", 1'b0, 3'd0, 3'd0);
        check("rstmid_entry", bus.RdData_A_RAU_OC, 256'd0);
        check("rstmid_other", bus.RdData_B_RAU_OC, 256'd0);
        check("rstmid_cnt2", 256'(bus.WbCount_RAU), 256'd0);

        // counter wrap: 65535 empty-mask writes, then one more
        cdb(1'b1, 3'd0, 3'd0, '0, 8'h00);
        for (int k = 0; k < 65535; k++) tick();
        cdb(1'b0, 3'd0, 3'd0, '0, 8'h00);
        tick();
        check_rel("wrap_last_rel", 1'b1, 3'd0, 3'd0);
        check("wrap_ffff", 256'(bus.WbCount_RAU), 256'hFFFF);
        tick();
        cdb(1'b1, 3'd5, 3'd3, pat, 8'h00);
        tick();
        cdb(1'b0, 3'd0, 3'd0, '0, 8'h00);
        tick();
        check_rel("wrap_rel", 1'b1, 3'd5, 3'd3);
        check("wrap_zero", 256'(bus.WbCount_RAU), 256'd0);
        rd_a(1'b1, 3'd5, 3'd3);
        tick();
        rd_a(1'b0, 3'd0, 3'd0);
        check("mask0_nochange", bus.RdData_A_RAU_OC, 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cdb_writeback_rf.md
Name: cdb_writeback_rf

Overview:
- Receiving end of the common data bus: consumes the single arbitrated CDB writeback stream (warp, register, 256-bit data, lane mask) inside the RAU.
- Commits each write into the per-warp physical register file with per-lane masking.
- Serves two synchronous operand-collector read ports.
- Pulses a register-release notification to the scoreboard for every committed write.

Parameters:
NUM_WARPS, 8, hardware warp slots (warp index width 3)
NUM_REGS, 8, registers per warp (register index width 3)
LANES, 8, lanes per warp (mask width)
LANE_W, 32, bits per lane; entry width = LANES*LANE_W = 256

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
RegWrite_CDB_RAU  in  1  CDB write valid
HWWarp_CDB_RAU  in  3  destination warp
WriteAddr_CDB_RAU  in  3  destination register
Data_CDB_RAU  in  256  write data; lane i = bits [32i+31:32i]
ActiveMask_CDB_RAU  in  8  per-lane write enable
RdEn_A_OC_RAU  in  1  read port A request
RdWarp_A_OC_RAU  in  3  port A warp
RdAddr_A_OC_RAU  in  3  port A register
RdEn_B_OC_RAU  in  1  read port B request
RdWarp_B_OC_RAU  in  3  port B warp
RdAddr_B_OC_RAU  in  3  port B register
RdData_A_RAU_OC  out  256  port A data
RdValid_A_RAU_OC  out  1  port A data valid
RdData_B_RAU_OC  out  256  port B data
RdValid_B_RAU_OC  out  1  port B data valid
Release_RAU_SB  out  1  one-cycle release pulse
ReleaseWarp_RAU_SB  out  3  released warp
ReleaseReg_RAU_SB  out  3  released register
WbCount_RAU  out  16  committed-write counter (debug)

Behaviour:
- Reset, sampled on posedge clk with rst_n=0: all 64 RF entries := 0; capture stage valid := 0; all outputs := 0. Reset mid-operation discards any captured, uncommitted write. That write produces no release and no counter increment.
- Stage C (capture): at edge E0 with RegWrite=1, latch warp, addr, data and mask; set cap_valid=1. RegWrite=0 clears cap_valid. Other CDB fields are ignored when RegWrite=0.
- Stage W (commit): at edge E1 (next edge) with cap_valid=1:
  - for each lane i with mask[i]=1, RF[warp][addr] lane i := captured data lane i; lanes with mask[i]=0 are unchanged.
  - WbCount_RAU += 1, wrapping 0xFFFF -> 0x0000.
- Release: in the cycle following E1, Release=1 with the committed warp/reg; otherwise Release=0 and warp/reg hold 0.
  - Latency from CDB input to release: 2 edges.
  - Mask=0x00 still commits (no data change), releases and counts.
- Throughput: one CDB write per cycle, no backpressure, no stall. Capture and commit of consecutive writes overlap.
- Reads, ports identical and independent:
  - request sampled at edge E; RdData/RdValid registered at E, so data appears the cycle after the request.
  - RdValid = sampled RdEn.
  - RdData when RdEn=0: holds previous value.
- Read/write collision is write-first:
  - if the commit at edge E targets the same warp/reg as a read sampled at E, RdData returns the masked-merged new value.
  - a write still only in stage C at E is not visible.
- Both ports may read the same entry in the same cycle; both return identical data.
- Consecutive writes to the same entry: the later write wins per lane. Lanes untouched by the later mask keep the earlier value.

Test Plan:
- Reset, then read A warp3/reg5 -> RdValid_A=1 next cycle, RdData_A=0; Release=0; WbCount=0.
- CDB write warp2/reg4, data lane i = 0x1000_0000+i, mask 0xFF at cycle t -> Release=1 with warp=2, reg=4 in cycle t+2 only; read at t+2 returns the full pattern; WbCount=1.
- Prior entry all 0xAAAAAAAA, write mask 0x0F with data 0x5555... -> lanes 0-3 = 0x55555555, lanes 4-7 = 0xAAAAAAAA.
- Write at t to warp1/reg1: read A at t+1 (same cycle as commit) returns new data (write-first); read B at t (write still in capture) returns old data.
- 8 back-to-back writes to distinct registers of warp7 -> 8 consecutive release pulses in order; WbCount += 8; all 8 reads match.
- Write captured at t, rst_n=0 at t+1 -> no release; entry = 0; WbCount=0. Separately, preload WbCount=0xFFFF via 65535 writes, one more write -> WbCount=0x0000.
